// File: rtl/branch_resolve_ctrl_if.sv
// Handshake/bus bundle between IF/EX stage logic and the branch resolve controller.
// master = pipeline side (drives fetch/ex info), slave = controller.
interface branch_resolve_ctrl_if #(
    parameter int QDEPTH = 4
);
    localparam int CW = $clog2(QDEPTH) + 1;

    logic          fetch_valid;
    logic          fetch_is_branch;
    logic [31:0]   fetch_pc;
    logic          fetch_pred_dir;
    logic          ex_valid;
    logic          ex_is_branch;
    logic          ex_taken;
    logic [31:0]   ex_target;
    logic          stall_fetch;
    logic          upd_valid;
    logic [31:0]   upd_pc;
    logic          upd_dir;
    logic          flush;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic [CW-1:0] q_count;
    logic          err_underflow;

    modport master (
        output fetch_valid, fetch_is_branch, fetch_pc, fetch_pred_dir,
        output ex_valid, ex_is_branch, ex_taken, ex_target,
        input  stall_fetch, upd_valid, upd_pc, upd_dir, flush,
        input  redirect_valid, redirect_pc, q_count, err_underflow
    );

    modport slave (
        input  fetch_valid, fetch_is_branch, fetch_pc, fetch_pred_dir,
        input  ex_valid, ex_is_branch, ex_taken, ex_target,
        output stall_fetch, upd_valid, upd_pc, upd_dir, flush,
        output redirect_valid, redirect_pc, q_count, err_underflow
    );
endinterface

// File: rtl/branch_resolve_ctrl.sv
// In-order branch queue resolving 1-bit predictions; update/redirect registered (1 cycle).
// Backpressure: stall_fetch while the queue is full; flush holds FLUSH_CYCLES after a mispredict.
module branch_resolve_ctrl #(
    parameter int QDEPTH       = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    branch_resolve_ctrl_if.slave bus
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic {IDLE, FLUSH} state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        dir;
    } entry_t;

    entry_t        q_mem [QDEPTH];
    entry_t        head;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [FW-1:0] flush_cnt;
    state_t        state;
    state_t        state_nxt;

    logic stall;
    logic resolve;
    logic pop;
    logic mispredict;
    logic do_push;
    logic underflow;

    assign head = q_mem[rd_ptr];

    always_comb begin
        stall      = (state == IDLE) && (count == CW'(QDEPTH));
        resolve    = (state == IDLE) && bus.ex_valid && bus.ex_is_branch;
        pop        = resolve && (count != '0);
        underflow  = resolve && (count == '0);
        mispredict = pop && (bus.ex_taken != head.dir);
        // A push in the mispredict cycle is wrong-path and is discarded.
        do_push    = (state == IDLE) && bus.fetch_valid && bus.fetch_is_branch
                     && !stall && !mispredict;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (mispredict) state_nxt = FLUSH;
            FLUSH:   if (flush_cnt == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Counter is preloaded while idle so it holds FLUSH_CYCLES-1 on entry.
    always_ff @(posedge clk) begin
        if (!rst)                 flush_cnt <= '0;
        else if (state == IDLE)   flush_cnt <= FW'(FLUSH_CYCLES - 1);
        else if (flush_cnt != '0) flush_cnt <= flush_cnt - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (do_push) q_mem[wr_ptr] <= '{pc: bus.fetch_pc, dir: bus.fetch_pred_dir};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (mispredict) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            bus.upd_valid      <= 1'b0;
            bus.upd_pc         <= '0;
            bus.upd_dir        <= 1'b0;
            bus.redirect_valid <= 1'b0;
            bus.redirect_pc    <= '0;
            bus.err_underflow  <= 1'b0;
        end else begin
            bus.upd_valid      <= pop;
            bus.redirect_valid <= mispredict;
            if (pop) begin
                bus.upd_pc  <= head.pc;
                bus.upd_dir <= bus.ex_taken;
            end
            if (mispredict)
                bus.redirect_pc <= bus.ex_taken ? bus.ex_target : head.pc + 32'd4;
            if (underflow)
                bus.err_underflow <= 1'b1;
        end
    end

    assign bus.stall_fetch = stall;
    assign bus.flush       = (state == FLUSH);
    assign bus.q_count     = count;
endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Bench for branch_resolve_ctrl: vector table for resolve/mispredict cases, scoreboard for full/wrap,
// hand sequences for underflow and reset during flush.
module tb_branch_resolve_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_total = 0;
    int   n_pass  = 0;

    always #5 clk = ~clk;

    branch_resolve_ctrl_if #(.QDEPTH(4)) bif ();

    branch_resolve_ctrl #(.QDEPTH(4), .FLUSH_CYCLES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.slave)
    );

    typedef struct {
        logic        fv, fb;
        logic [31:0] fpc;
        logic        fd;
        logic        ev, eb, et;
        logic [31:0] tgt;
        logic        uv;
        logic [31:0] upc;
        logic        ud, fl, rv;
        logic [31:0] rpc;
        logic [2:0]  cnt;
        logic        st, err;
    } vec_t;

    vec_t       tbl [20];
    logic [32:0] mq [$];
    logic [32:0] sb [$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step(input logic fv, input logic fb, input logic [31:0] fpc, input logic fd,
                        input logic ev, input logic eb, input logic et, input logic [31:0] tgt);
        bif.fetch_valid     = fv;
        bif.fetch_is_branch = fb;
        bif.fetch_pc        = fpc;
        bif.fetch_pred_dir  = fd;
        bif.ex_valid        = ev;
        bif.ex_is_branch    = eb;
        bif.ex_taken        = et;
        bif.ex_target       = tgt;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t v(input logic fv, input logic fb, input logic [31:0] fpc, input logic fd,
                               input logic ev, input logic eb, input logic et, input logic [31:0] tgt,
                               input logic uv, input logic [31:0] upc, input logic ud,
                               input logic fl, input logic rv, input logic [31:0] rpc,
                               input logic [2:0] cnt, input logic st, input logic err);
        vec_t r;
        r.fv = fv; r.fb = fb; r.fpc = fpc; r.fd = fd;
        r.ev = ev; r.eb = eb; r.et = et; r.tgt = tgt;
        r.uv = uv; r.upc = upc; r.ud = ud; r.fl = fl; r.rv = rv; r.rpc = rpc;
        r.cnt = cnt; r.st = st; r.err = err;
        return r;
    endfunction

    function automatic logic [127:0] all_out();
        return {bif.upd_valid, bif.upd_pc, bif.upd_dir, bif.flush, bif.redirect_valid,
                bif.redirect_pc, bif.q_count, bif.stall_fetch, bif.err_underflow};
    endfunction

    // Queue-full/wrap step: the bench FIFO follows the drop-when-full rule.
    task automatic fstep(input string name, input logic dp, input logic [31:0] pc,
                         input logic pd, input logic dpop);
        logic full;
        logic et;
        logic [32:0] e;
        full = (mq.size() == 4);
        et = 1'b0;
        if (dpop) begin
            et = mq[0][0];
            sb.push_back(mq[0]);
            void'(mq.pop_front());
        end
        if (dp && !full) mq.push_back({pc, pd});
        step(dp, 1'b1, pc, pd, dpop, 1'b1, et, 32'h0);
        chk({name, ".upd_valid"}, bif.upd_valid, dpop);
        if (bif.upd_valid && sb.size() > 0) begin
            e = sb.pop_front();
            chk({name, ".upd"}, {bif.upd_pc, bif.upd_dir}, e);
        end
        chk({name, ".q_count"}, bif.q_count, mq.size());
        chk({name, ".stall"}, bif.stall_fetch, mq.size() == 4);
        chk({name, ".flush"}, bif.flush, 1'b0);
    endtask

    initial begin
        vec_t        r;
        logic [127:0] a, x;

        tbl[0]  = v(0,0,32'h0,0,         0,0,0,32'h0,   0,32'h0,0,       0,0,32'h0, 0,0,0);
        tbl[1]  = v(1,1,32'h40,0,        0,0,0,32'h0,   0,32'h0,0,       0,0,32'h0, 1,0,0);
        tbl[2]  = v(0,0,32'h0,0,         1,1,0,32'h0,   1,32'h40,0,      0,0,32'h0, 0,0,0);
        tbl[3]  = v(1,1,32'h40,0,        0,0,0,32'h0,   0,32'h0,0,       0,0,32'h0, 1,0,0);
        tbl[4]  = v(1,1,32'h44,1,        0,0,0,32'h0,   0,32'h0,0,       0,0,32'h0, 2,0,0);
        tbl[5]  = v(0,0,32'h0,0,         1,1,1,32'h100, 1,32'h40,1,      1,1,32'h100, 0,0,0);
        tbl[6]  = v(1,1,32'h200,0,       1,1,1,32'h0,   0,32'h0,0,       1,0,32'h0, 0,0,0);
        tbl[7]  = v(0,0,32'h0,0,         0,0,0,32'h0,   0,32'h0,0,       0,0,32'h0, 0,0,0);
        tbl[8]  = v(1,1,32'h80,1,        0,0,0,32'h0,   0,32'h0,0,       0,0,32'h0, 1,0,0);
        tbl[9]  = v(1,1,32'h90,0,        1,1,0,32'h300, 1,32'h80,0,      1,1,32'h84, 0,0,0);
        tbl[10] = v(0,0,32'h0,0,         0,0,0,32'h0,   0,32'h0,0,       1,0,32'h0, 0,0,0);
        tbl[11] = v(0,0,32'h0,0,         0,0,0,32'h0,   0,32'h0,0,       0,0,32'h0, 0,0,0);
        tbl[12] = v(1,1,32'h10,1,        0,0,0,32'h0,   0,32'h0,0,       0,0,32'h0, 1,0,0);
        tbl[13] = v(1,1,32'h14,0,        1,1,1,32'h0,   1,32'h10,1,      0,0,32'h0, 1,0,0);
        tbl[14] = v(0,0,32'h0,0,         1,1,0,32'h0,   1,32'h14,0,      0,0,32'h0, 0,0,0);
        tbl[15] = v(1,1,32'hFFFFFFFC,1,  0,0,0,32'h0,   0,32'h0,0,       0,0,32'h0, 1,0,0);
        tbl[16] = v(0,0,32'h0,0,         1,1,0,32'h500, 1,32'hFFFFFFFC,0, 1,1,32'h0, 0,0,0);
        tbl[17] = v(0,0,32'h0,0,         0,0,0,32'h0,   0,32'h0,0,       1,0,32'h0, 0,0,0);
        tbl[18] = v(0,0,32'h0,0,         0,0,0,32'h0,   0,32'h0,0,       0,0,32'h0, 0,0,0);
        tbl[19] = v(1,0,32'h600,1,       1,0,1,32'h0,   0,32'h0,0,       0,0,32'h0, 0,0,0);

        bif.fetch_valid = 0; bif.fetch_is_branch = 0; bif.fetch_pc = 0; bif.fetch_pred_dir = 0;
        bif.ex_valid = 0; bif.ex_is_branch = 0; bif.ex_taken = 0; bif.ex_target = 0;

        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", all_out(), 128'h0);
        rst = 1'b1;
        step(0,0,0,0, 0,0,0,0);
        chk("idle_after_reset", all_out(), 128'h0);

        for (int i = 0; i < 20; i++) begin
            r = tbl[i];
            step(r.fv, r.fb, r.fpc, r.fd, r.ev, r.eb, r.et, r.tgt);
            // Held pc values are only meaningful while their valid strobe is up.
            a = {bif.upd_valid, bif.upd_valid ? bif.upd_pc : 32'h0, bif.upd_valid & bif.upd_dir,
                 bif.flush, bif.redirect_valid, bif.redirect_valid ? bif.redirect_pc : 32'h0,
                 bif.q_count, bif.stall_fetch, bif.err_underflow};
            x = {r.uv, r.uv ? r.upc : 32'h0, r.uv & r.ud, r.fl, r.rv, r.rv ? r.rpc : 32'h0,
                 r.cnt, r.st, r.err};
            chk($sformatf("vec%0d", i), a, x);
        end

        for (int i = 0; i < 4; i++)
            fstep($sformatf("fill%0d", i), 1'b1, 32'h1000 + 32'(i) * 4, i[0], 1'b0);
        fstep("push_when_full", 1'b1, 32'h2000, 1'b1, 1'b0);
        fstep("pushpop_when_full", 1'b1, 32'h2004, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++)
            fstep($sformatf("pushpop%0d", i), 1'b1, 32'h3000 + 32'(i) * 4, ~i[0], 1'b1);
        for (int i = 0; i < 3; i++)
            fstep($sformatf("drain%0d", i), 1'b0, 32'h0, 1'b0, 1'b1);
        chk("scoreboard_empty", sb.size(), 0);

        step(0,0,0,0, 1,1,0,0);
        chk("underflow.err", bif.err_underflow, 1'b1);
        chk("underflow.upd_valid", bif.upd_valid, 1'b0);
        chk("underflow.flush_cnt", {bif.flush, bif.q_count}, 4'h0);
        step(0,0,0,0, 0,0,0,0);
        chk("underflow.sticky", bif.err_underflow, 1'b1);
        step(1,1,32'h500,0, 0,0,0,0);
        step(0,0,0,0, 1,1,1,32'h600);
        chk("mid_flush.entered", {bif.flush, bif.redirect_valid, bif.redirect_pc}, {2'b11, 32'h600});
        rst = 1'b0;
        step(0,0,0,0, 0,0,0,0);
        chk("reset_mid_flush", all_out(), 128'h0);
        rst = 1'b1;
        step(0,0,0,0, 0,0,0,0);
        chk("after_reset_idle", all_out(), 128'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
